// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD subtractor.
// Holds the FSM state enum, the BCD digit type and the single-digit subtract-with-borrow function.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_SUB   = 3'd2,
        ST_FIX   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        bcd_digit_t digit;
        logic       borrow;
    } digit_res_t;

    // Bit 4 of the 5-bit difference is the sign; a negative digit wraps by adding ten.
    function automatic digit_res_t bcd_sub_digit(input bcd_digit_t x, input bcd_digit_t y,
                                                 input logic bin);
        logic [4:0] t;
        digit_res_t r;
        t = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
        if (t[4]) begin
            r.digit  = t[3:0] + 4'd10;
            r.borrow = 1'b1;
        end else begin
            r.digit  = t[3:0];
            r.borrow = 1'b0;
        end
        return r;
    endfunction

    function automatic logic digit_invalid(input bcd_digit_t d);
        return (d > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_sub_serial_if.sv
// Handshake and operand/result bundle of the digit-serial BCD subtractor.
interface bcd_sub_serial_if #(parameter int DIGITS = 4);

    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   diff;
    logic                  borrow_out;
    logic                  neg;
    logic                  err;

    modport master (output start, a, b,
                    input  busy, done, diff, borrow_out, neg, err);

    modport slave  (input  start, a, b,
                    output busy, done, diff, borrow_out, neg, err);

endinterface

// File: rtl/bcd_digit_sub.sv
// Combinational single BCD digit subtractor: d = x - y - bin, with borrow out.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  bcd_digit_t x,
    input  bcd_digit_t y,
    input  logic       bin,
    output bcd_digit_t d,
    output logic       bout
);

    digit_res_t res_s;

    assign res_s = bcd_sub_digit(x, y, bin);
    assign d     = res_s.digit;
    assign bout  = res_s.borrow;

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor (A - B, LSD first) with start/busy/done handshake.
// Define BCD_SUB_SIGN_MAG_EN for sign-magnitude results (extra FIX pass); otherwise ten's complement.
module bcd_sub_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    bcd_sub_serial_if.slave   bus
);

    localparam logic [2:0] LAST_K = 3'(DIGITS - 1);

    state_t              state_r;
    state_t              state_s;
    logic [4*DIGITS-1:0] a_r;
    logic [4*DIGITS-1:0] b_r;
    logic [4*DIGITS-1:0] diff_r;
    logic [2:0]          k_r;
    logic                borrow_r;
    logic                busy_r;
    logic                done_r;
    logic                borrow_out_r;
    logic                neg_r;
    logic                err_r;

    logic                bad_s;
    logic [4:0]          sel_s;
    bcd_digit_t          x_s;
    bcd_digit_t          y_s;
    bcd_digit_t          dig_s;
    logic                bout_s;

    // Flags any latched operand digit outside 0..9.
    always_comb begin
        bad_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad_s = bad_s | digit_invalid(a_r[4*i +: 4]) | digit_invalid(b_r[4*i +: 4]);
        end
    end

    // The FIX pass negates the stored result in place: 0 - diff_k - borrow.
    always_comb begin
        sel_s = {k_r, 2'b00};
        if (state_r == ST_FIX) begin
            x_s = 4'd0;
            y_s = diff_r[sel_s +: 4];
        end else begin
            x_s = a_r[sel_s +: 4];
            y_s = b_r[sel_s +: 4];
        end
    end

    bcd_digit_sub u_digit_sub (
        .x    (x_s),
        .y    (y_s),
        .bin  (borrow_r),
        .d    (dig_s),
        .bout (bout_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_s = ST_CHECK;
                else           state_s = ST_IDLE;
            end
            ST_CHECK: begin
                if (bad_s) state_s = ST_DONE;
                else       state_s = ST_SUB;
            end
            ST_SUB: begin
                if (k_r == LAST_K) begin
`ifdef BCD_SUB_SIGN_MAG_EN
                    if (bout_s) state_s = ST_FIX;
                    else        state_s = ST_DONE;
`else
                    state_s = ST_DONE;
`endif
                end else begin
                    state_s = ST_SUB;
                end
            end
            ST_FIX: begin
                if (k_r == LAST_K) state_s = ST_DONE;
                else               state_s = ST_FIX;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Operand latch, serial datapath and registered outputs; done/busy change on the edge entering DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r          <= '0;
            b_r          <= '0;
            diff_r       <= '0;
            k_r          <= 3'd0;
            borrow_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            borrow_out_r <= 1'b0;
            neg_r        <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_r          <= bus.a;
                        b_r          <= bus.b;
                        diff_r       <= '0;
                        k_r          <= 3'd0;
                        borrow_r     <= 1'b0;
                        busy_r       <= 1'b1;
                        borrow_out_r <= 1'b0;
                        neg_r        <= 1'b0;
                        err_r        <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (bad_s) begin
                        err_r        <= 1'b1;
                        diff_r       <= '0;
                        borrow_out_r <= 1'b0;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                    end
                end
                ST_SUB: begin
                    diff_r[sel_s +: 4] <= dig_s;
                    borrow_r           <= bout_s;
                    k_r                <= k_r + 3'd1;
                    if (k_r == LAST_K) begin
                        k_r          <= 3'd0;
                        borrow_r     <= 1'b0;
                        borrow_out_r <= bout_s;
`ifdef BCD_SUB_SIGN_MAG_EN
                        if (bout_s) begin
                            neg_r <= 1'b1;
                        end else begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
`else
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
`endif
                    end
                end
                ST_FIX: begin
                    diff_r[sel_s +: 4] <= dig_s;
                    borrow_r           <= bout_s;
                    k_r                <= k_r + 3'd1;
                    if (k_r == LAST_K) begin
                        k_r    <= 3'd0;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.diff       = diff_r;
    assign bus.borrow_out = borrow_out_r;
    assign bus.neg        = neg_r;
    assign bus.err        = err_r;

endmodule
